// File: rtl/line_engine_arbiter_pkg.sv
// Shared types and constants for the line-engine arbiter slice.
// Build option: LINE_ARB_TIMEOUT_EN enables the DRAW watchdog and the ABORT path.
package line_arb_pkg;

  localparam int MAX_REQ     = 4;
  localparam int IDX_W       = 2;   // enough to index MAX_REQ requesters
  localparam int TMO_W       = 16;
  localparam int COORD_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_GAP   = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

  // Held at the widest legal coordinate; the top narrows it to COORD_W on output.
  typedef struct packed {
    logic [COORD_MAX_W-1:0] x0;
    logic [COORD_MAX_W-1:0] y0;
    logic [COORD_MAX_W-1:0] x1;
    logic [COORD_MAX_W-1:0] y1;
  } seg_t;

endpackage

// File: rtl/line_engine_arbiter_if.sv
// Requester and engine-side signals of the line-engine arbiter.
// master = the arbiter itself, slave = requesters plus engine.
interface line_engine_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = 8
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*4*COORD_W-1:0] req_coords;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic                         eng_draw_en;
  logic [COORD_W-1:0]           eng_x0;
  logic [COORD_W-1:0]           eng_y0;
  logic [COORD_W-1:0]           eng_x1;
  logic [COORD_W-1:0]           eng_y1;
  logic                         eng_draw_done;
  logic                         busy;
  logic                         err;

  modport master (
    input  req, req_coords, eng_draw_done,
    output grant, done, eng_draw_en, eng_x0, eng_y0, eng_x1, eng_y1, busy, err
  );

  modport slave (
    output req, req_coords, eng_draw_done,
    input  grant, done, eng_draw_en, eng_x0, eng_y0, eng_x1, eng_y1, busy, err
  );

endinterface

// File: rtl/line_engine_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at ptr, ptr+1, ... mod NUM_REQ.
module rr_picker
  import line_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_winner
);

  logic [MAX_REQ-1:0] w_req;
  logic [IDX_W-1:0]   w_idx;

  assign w_req = MAX_REQ'(i_req);

  // Scan farthest-first so the nearest set bit to ptr is the last one written.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (w_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/line_engine_arbiter.sv
// Round-robin owner of the shared Bresenham engine: latch one segment, draw it, pulse done.
// Build option: LINE_ARB_TIMEOUT_EN adds a DRAW watchdog, the ABORT state and the sticky err flag.
module line_engine_arbiter
  import line_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int COORD_W        = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   n_rst,
  line_engine_arbiter_if.master arb
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || COORD_W < 1 || COORD_W > COORD_MAX_W ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("line_engine_arbiter: illegal parameter set");
  end

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_sel;
  logic [IDX_W-1:0]     w_win;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic                 w_valid;
  logic                 w_drawing;
  logic                 w_retire;
  logic                 w_accept;
  logic [4*COORD_W-1:0] w_slice;
  seg_t                 r_seg;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req    (arb.req),
    .i_ptr    (r_ptr),
    .o_valid  (w_valid),
    .o_winner (w_win)
  );

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) w_slice = arb.req_coords[i*4*COORD_W +: 4*COORD_W];
    end
  end

`ifdef LINE_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_cnt;
  logic             r_err;
  logic             w_tmo;

  // r_cnt holds the number of DRAW cycles already completed for this segment.
  assign w_tmo   = (r_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign arb.err = r_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept)                r_cnt <= '0;
      else if (r_state == ST_DRAW) r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_ABORT)     r_err <= 1'b1;
    end
  end
`else
  assign arb.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) w_state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        if (arb.eng_draw_done) w_state_nxt = ST_GAP;
`ifdef LINE_ARB_TIMEOUT_EN
        else if (w_tmo) w_state_nxt = ST_ABORT;
`endif
      end
      ST_GAP:   w_state_nxt = ST_IDLE;
      ST_ABORT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && w_valid;
  assign w_drawing = (r_state == ST_DRAW);
  assign w_retire  = (r_state == ST_GAP) || (r_state == ST_ABORT);
  assign w_ptr_nxt = (r_sel == IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr <= '0;
      r_sel <= '0;
      r_seg <= '0;
    end else begin
      if (w_accept) begin
        r_sel    <= w_win;
        r_seg.x0 <= COORD_MAX_W'(w_slice[0*COORD_W +: COORD_W]);
        r_seg.y0 <= COORD_MAX_W'(w_slice[1*COORD_W +: COORD_W]);
        r_seg.x1 <= COORD_MAX_W'(w_slice[2*COORD_W +: COORD_W]);
        r_seg.y1 <= COORD_MAX_W'(w_slice[3*COORD_W +: COORD_W]);
      end
      if (w_retire) r_ptr <= w_ptr_nxt;
    end
  end

  // Outputs decode straight from state so reset drops them without waiting for a clock.
  always_comb begin
    arb.grant = '0;
    arb.done  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb.grant[i] = w_drawing && (r_sel == IDX_W'(i));
      arb.done[i]  = w_retire  && (r_sel == IDX_W'(i));
    end
  end

  assign arb.eng_draw_en = w_drawing;
  assign arb.eng_x0      = w_drawing ? COORD_W'(r_seg.x0) : '0;
  assign arb.eng_y0      = w_drawing ? COORD_W'(r_seg.y0) : '0;
  assign arb.eng_x1      = w_drawing ? COORD_W'(r_seg.x1) : '0;
  assign arb.eng_y1      = w_drawing ? COORD_W'(r_seg.y1) : '0;
  assign arb.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_line_engine_arbiter.sv
// Bench for line_engine_arbiter: engine model, round-robin scoreboard, vector table, corner sequences.
module tb_line_engine_arbiter;

  localparam int N  = 3;
  localparam int CW = 8;

  typedef struct {
    int          idx;
    logic [31:0] seg;   // {x0,y0,x1,y1}
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    int           lat;
    int           first;
    int           cnt;
  } vec_t;

  logic clk;
  logic n_rst;

  line_engine_arbiter_if #(.NUM_REQ(N), .COORD_W(CW)) arb ();

  line_engine_arbiter #(.NUM_REQ(N), .COORD_W(CW), .TIMEOUT_CYCLES(20)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  int           n_done = 0;
  exp_t         exp_q[$];
  int           m_ptr = 0;
  int           eng_k = 0;
  int           eng_lat = 1;
  bit           eng_hang = 1'b0;
  bit           auto_drop = 1'b1;
  logic [31:0]  cap_seg = '0;
  logic [N-1:0] cap_grant = '0;
  vec_t         vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] cur_seg();
    return {arb.eng_x0, arb.eng_y0, arb.eng_x1, arb.eng_y1};
  endfunction

  function automatic logic [31:0] seg_of(input int r);
    logic [31:0] s;
    s = arb.req_coords[r*32 +: 32];   // slice packed {y1,x1,y0,x0}
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  task automatic set_coords(input int r, input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1);
    arb.req_coords[r*32 +: 32] = {y1, x1, y0, x0};
  endtask

  // Reference round-robin: every requester in mask is pending at the same arbitration.
  task automatic push_order(input logic [N-1:0] mask);
    int last;
    last = -1;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (m_ptr + i) % N;
      if (mask[idx]) begin
        exp_q.push_back('{idx, seg_of(idx)});
        last = idx;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % N;
  endtask

  // One clock: engine model, scoreboard on done, requester drop after service.
  task automatic step();
    exp_t         e;
    logic [N-1:0] oh;
    @(negedge clk);
    if (arb.eng_draw_en) eng_k++;
    else                 eng_k = 0;
    arb.eng_draw_done = arb.eng_draw_en && (eng_k == eng_lat) && !eng_hang;
    if (arb.eng_draw_en) begin
      if (eng_k == 1) begin
        cap_grant = arb.grant;
        cap_seg   = cur_seg();
        chk("grant_onehot", 32'($onehot(arb.grant)), 32'd1);
      end else begin
        chk("eng_hold", cur_seg(), cap_seg);
      end
    end
    if (arb.done != '0) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(arb.done), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        oh = N'(1) << e.idx;
        chk("done_winner", 32'(arb.done), 32'(oh));
        chk("done_vs_grant", 32'(arb.done), 32'(cap_grant));
        chk("seg_served", cap_seg, e.seg);
      end
      if (auto_drop) arb.req = arb.req & ~arb.done;
    end
  endtask

  task automatic wait_en(input logic lvl, input int budget, input string nm);
    int b;
    b = budget;
    while (arb.eng_draw_en !== lvl && b > 0) begin
      step();
      b--;
    end
    chk(nm, 32'(arb.eng_draw_en), 32'(lvl));
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while ((exp_q.size() != 0 || arb.busy) && b > 0) begin
      step();
      b--;
    end
    chk("drain", 32'(exp_q.size() == 0 && !arb.busy), 32'd1);
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    step();
    step();
    n_rst = 1'b1;
    step();
    m_ptr = 0;
    exp_q.delete();
  endtask

  initial begin
    int gap, cnt, d0;

    vt[0] = '{3'b001, 1, 0, 1};
    vt[1] = '{3'b010, 3, 1, 1};
    vt[2] = '{3'b111, 2, 2, 3};
    vt[3] = '{3'b101, 4, 2, 2};
    vt[4] = '{3'b110, 1, 1, 2};
    vt[5] = '{3'b111, 1, 0, 3};
    vt[6] = '{3'b011, 6, 0, 2};
    vt[7] = '{3'b100, 2, 2, 1};

    n_rst             = 1'b0;
    arb.req           = '0;
    arb.req_coords    = '0;
    arb.eng_draw_done = 1'b0;
    step();
    step();
    chk("rst_busy",  32'(arb.busy), 32'd0);
    chk("rst_grant", 32'(arb.grant), 32'd0);
    chk("rst_done",  32'(arb.done), 32'd0);
    chk("rst_en",    32'(arb.eng_draw_en), 32'd0);
    chk("rst_seg",   cur_seg(), 32'd0);
    chk("rst_err",   32'(arb.err), 32'd0);
    n_rst = 1'b1;
    step();

    // Single request, exact cycle timing (cycle 0 = request seen in IDLE).
    set_coords(0, 8'd2, 8'd3, 8'd10, 8'd7);
    eng_lat = 5;
    arb.req = 3'b001;
    push_order(3'b001);
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c <= 5) begin
        chk("single_en",  32'(arb.eng_draw_en), 32'd1);
        chk("single_seg", cur_seg(), 32'h02030A07);
      end
      if (c == 1) chk("single_grant", 32'(arb.grant), 32'b001);
      if (c == 6) begin
        chk("single_done",   32'(arb.done), 32'b001);
        chk("single_gap_en", 32'(arb.eng_draw_en), 32'd0);
      end
      if (c == 7) chk("single_busy_low", 32'(arb.busy), 32'd0);
    end
    wait_idle(20);

    // Simultaneous requests straight after reset: 0 first, then 1 after a 2-cycle gap.
    pulse_reset();
    set_coords(1, 8'd40, 8'd41, 8'd42, 8'd43);
    eng_lat = 3;
    arb.req = 3'b011;
    push_order(3'b011);
    wait_en(1'b1, 10, "simul_start");
    chk("simul_first", 32'(arb.grant), 32'b001);
    wait_en(1'b0, 20, "simul_end0");
    gap = 0;
    while (!arb.eng_draw_en && gap < 10) begin
      gap++;
      step();
    end
    chk("simul_gap", 32'(gap), 32'd2);
    chk("simul_second", 32'(arb.grant), 32'b010);
    wait_idle(40);

    // Vector table: requests raised together, dropped by each requester after its done.
    foreach (vt[v]) begin
      for (int r = 0; r < N; r++)
        set_coords(r, 8'(16*v + 4*r), 8'(16*v + 4*r + 1), 8'(16*v + 4*r + 2), 8'(16*v + 4*r + 3));
      eng_lat = vt[v].lat;
      d0      = n_done;
      arb.req = vt[v].mask;
      push_order(vt[v].mask);
      wait_en(1'b1, 10, "vec_start");
      chk("vec_first", 32'(arb.grant), 32'(N'(1) << vt[v].first));
      wait_idle(100);
      chk("vec_count", 32'(n_done - d0), 32'(vt[v].cnt));
      step();
    end

    // Withdraw request and scramble coordinates mid-draw: segment still completes intact.
    set_coords(1, 8'd100, 8'd101, 8'd102, 8'd103);
    eng_lat = 4;
    d0      = n_done;
    arb.req = 3'b010;
    push_order(3'b010);
    wait_en(1'b1, 10, "wd_start");
    step();
    arb.req = 3'b000;
    set_coords(1, 8'd200, 8'd201, 8'd202, 8'd203);
    wait_idle(30);
    chk("wd_done", 32'(n_done - d0), 32'd1);

    // Reset mid-draw with ptr parked at 1: afterwards requester 0 must win again.
    set_coords(0, 8'd5, 8'd6, 8'd7, 8'd8);
    eng_lat = 2;
    arb.req = 3'b001;
    push_order(3'b001);
    wait_idle(30);
    eng_lat = 6;
    arb.req = 3'b010;
    wait_en(1'b1, 10, "rst_mid_start");
    step();
    n_rst = 1'b0;
    #1;
    chk("rst_mid_en",    32'(arb.eng_draw_en), 32'd0);
    chk("rst_mid_grant", 32'(arb.grant), 32'd0);
    chk("rst_mid_busy",  32'(arb.busy), 32'd0);
    arb.req = 3'b000;
    step();
    chk("rst_mid_nodone", 32'(arb.done), 32'd0);
    n_rst = 1'b1;
    m_ptr = 0;
    exp_q.delete();
    step();
    eng_lat = 2;
    arb.req = 3'b011;
    push_order(3'b011);
    wait_en(1'b1, 10, "rst_after_start");
    chk("rst_after_first", 32'(arb.grant), 32'b001);
    wait_idle(40);

    // Fairness: three requesters held continuously for two full rounds.
    pulse_reset();
    auto_drop = 1'b0;
    eng_lat   = 2;
    arb.req   = 3'b111;
    push_order(3'b111);
    push_order(3'b111);
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 6; c++) begin
      step();
      if (arb.done != '0) cnt++;
    end
    arb.req   = 3'b000;
    auto_drop = 1'b1;
    chk("fair_served", 32'(cnt), 32'd6);
    wait_idle(20);

`ifdef LINE_ARB_TIMEOUT_EN
    // Engine never finishes: ABORT after 20 DRAW cycles, err sticks, next segment served.
    eng_hang = 1'b1;
    arb.req  = 3'b001;
    push_order(3'b001);
    wait_en(1'b1, 10, "tmo_start");
    cnt = 0;
    while (arb.eng_draw_en && cnt < 100) begin
      cnt++;
      step();
    end
    chk("tmo_draw_cycles", 32'(cnt), 32'd20);
    chk("tmo_done", 32'(arb.done), 32'b001);
    step();
    chk("tmo_err_set", 32'(arb.err), 32'd1);
    eng_hang = 1'b0;
    eng_lat  = 3;
    arb.req  = 3'b001;
    push_order(3'b001);
    wait_idle(30);
    chk("tmo_err_sticky", 32'(arb.err), 32'd1);
`else
    chk("err_tied_low", 32'(arb.err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
